// File: rtl/ustream_to_bin.sv
// ustream_to_bin
//   Converts a unary bitstream back to binary. The block counts the ones in fixed windows of
//   2**BITWIDTH valid samples. Each window result is presented on a valid/ready output port.
//
// Parameters
//   BITWIDTH    log2 of the window length W.
//   BIPOLAR     0: oData = count of ones. 1: oData = 2*count - W, in two's complement.
//   CONTINUOUS  1: the next window starts straight after the current one. 0: return to idle.
//
// Ports
//   iClk     clock; all state changes on the rising edge
//   iRstN    asynchronous active-low reset
//   iClr     synchronous clear: abort the window, drop the pending result, clear oOvf
//   iStart   begin a window (ignored unless idle)
//   iEn      iStream carries a valid sample this cycle
//   iStream  unary input bit
//   oData    window result (BITWIDTH+2 bits; unipolar zero-extended, bipolar signed)
//   oValid   oData holds a result that has not been consumed
//   iReady   consumer takes oData when oValid && iReady
//   oBusy    a window is being accumulated
//   oOvf     sticky: a result was overwritten before it was consumed
module ustream_to_bin #(
  parameter int unsigned BITWIDTH   = 4,
  parameter bit          BIPOLAR    = 1'b0,
  parameter bit          CONTINUOUS = 1'b1
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iClr,
  input  logic                iStart,
  input  logic                iEn,
  input  logic                iStream,
  output logic [BITWIDTH+1:0] oData,
  output logic                oValid,
  input  logic                iReady,
  output logic                oBusy,
  output logic                oOvf
);

  localparam int unsigned OutW = BITWIDTH + 2;
  localparam logic [OutW-1:0] WinLen = OutW'(2 ** BITWIDTH);

  typedef enum logic [0:0] {StIdle, StAcc} state_e;

  state_e              state_q;
  logic [BITWIDTH-1:0] smp_cnt_q;
  logic [BITWIDTH:0]   ones_q;

  logic                last_smp;
  logic [BITWIDTH:0]   ones_total;
  logic [OutW-1:0]     result;

  always_comb begin
    // The sample counter is all ones on the last sample of a window.
    last_smp   = (state_q == StAcc) && iEn && (&smp_cnt_q);
    // The ones counter is one bit wider than the sample counter, so a full window of W ones
    // still fits.
    ones_total = ones_q + {{BITWIDTH{1'b0}}, iStream};
    if (BIPOLAR) begin
      result = {ones_total, 1'b0} - WinLen;
    end else begin
      result = {1'b0, ones_total};
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q   <= StIdle;
      smp_cnt_q <= '0;
      ones_q    <= '0;
      oData     <= '0;
      oValid    <= 1'b0;
      oOvf      <= 1'b0;
    end else if (iClr) begin
      state_q   <= StIdle;
      smp_cnt_q <= '0;
      ones_q    <= '0;
      oValid    <= 1'b0;
      oOvf      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (iStart) begin
            state_q   <= StAcc;
            smp_cnt_q <= '0;
            ones_q    <= '0;
          end
        end
        StAcc: begin
          if (last_smp) begin
            // Restart on the same edge, so back-to-back windows lose no samples.
            smp_cnt_q <= '0;
            ones_q    <= '0;
            if (!CONTINUOUS) state_q <= StIdle;
          end else if (iEn) begin
            smp_cnt_q <= smp_cnt_q + 1'b1;
            ones_q    <= ones_total;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (last_smp) begin
        oData  <= result;
        oValid <= 1'b1;
        // A handshake on this same edge consumes the old result, so that case is not an overflow.
        if (oValid && !iReady) oOvf <= 1'b1;
      end else if (oValid && iReady) begin
        oValid <= 1'b0;
      end
    end
  end

  assign oBusy = (state_q == StAcc);

endmodule

// File: tb/tb_ustream_to_bin.sv
module tb_ustream_to_bin;

  logic iClk = 1'b0;
  always #5 iClk = ~iClk;

  logic iRstN, iClr, iStart, iEn, iStream, iReady;
  logic [5:0] u_data, b_data;
  logic u_valid, u_busy, u_ovf, b_valid, b_busy, b_ovf;

  // Unipolar, continuous instance (default parameters).
  ustream_to_bin #(.BITWIDTH(4), .BIPOLAR(1'b0), .CONTINUOUS(1'b1)) dut (
    .iClk(iClk), .iRstN(iRstN), .iClr(iClr), .iStart(iStart), .iEn(iEn), .iStream(iStream),
    .oData(u_data), .oValid(u_valid), .iReady(iReady), .oBusy(u_busy), .oOvf(u_ovf)
  );

  // Bipolar, single-shot instance. It shares the same stimulus.
  ustream_to_bin #(.BITWIDTH(4), .BIPOLAR(1'b1), .CONTINUOUS(1'b0)) dut_bp (
    .iClk(iClk), .iRstN(iRstN), .iClr(iClr), .iStart(iStart), .iEn(iEn), .iStream(iStream),
    .oData(b_data), .oValid(b_valid), .iReady(iReady), .oBusy(b_busy), .oOvf(b_ovf)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic clear_pulse();
    iClr = 1'b1;
    step();
    iClr = 1'b0;
  endtask

  task automatic start_pulse();
    iStart = 1'b1;
    step();
    iStart = 1'b0;
  endtask

  // Feed one window of 16 samples, LSB first. If gap is set, an idle cycle comes before each
  // sample. iReady is 0 except on the last sample, where it takes the value rdy_last.
  // After sample 15 the task checks the held output: hold_exp < 0 means no result is pending.
  task automatic feed(input logic [15:0] bits, input bit gap, input bit rdy_last,
                      input int hold_exp, input string tag);
    for (int i = 0; i < 16; i++) begin
      if (gap) begin
        iEn = 1'b0;
        step();
      end
      iEn     = 1'b1;
      iStream = bits[i];
      iReady  = (i == 15) ? rdy_last : 1'b0;
      step();
      if (i == 14) begin
        check({tag, "_pre_valid"}, 32'(u_valid), (hold_exp >= 0) ? 32'd1 : 32'd0);
        if (hold_exp >= 0) check({tag, "_hold_data"}, 32'(u_data), 32'(hold_exp));
      end
    end
    iEn     = 1'b0;
    iStream = 1'b0;
    iReady  = 1'b0;
  endtask

  // Table of single windows. exp_b is the bipolar result 2*ones-16 as a 6-bit pattern.
  typedef struct {
    logic [15:0] bits;
    bit          gap;
    int          exp_u;
    int          exp_b;
  } win_t;

  win_t tbl[6];

  // Reference model: one set of integer state per instance (0 = unipolar/continuous,
  // 1 = bipolar/single-shot).
  bit m_act[2], m_valid[2], m_ovf[2];
  int m_n[2], m_ones[2], m_data[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_valid[k] = 0; m_ovf[k] = 0;
      m_n[k] = 0; m_ones[k] = 0; m_data[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit clr, input bit start, input bit en,
                            input bit s, input bit rdy);
    bit done;
    int res;
    done = 0;
    res  = 0;
    if (clr) begin
      m_act[k] = 0; m_n[k] = 0; m_ones[k] = 0; m_valid[k] = 0; m_ovf[k] = 0;
    end else begin
      if (!m_act[k]) begin
        if (start) begin
          m_act[k] = 1; m_n[k] = 0; m_ones[k] = 0;
        end
      end else if (en) begin
        m_n[k]    = m_n[k] + 1;
        m_ones[k] = m_ones[k] + int'(s);
        if (m_n[k] == 16) begin
          done     = 1;
          res      = (k == 1) ? (2 * m_ones[k] - 16) : m_ones[k];
          m_n[k]   = 0;
          m_ones[k] = 0;
          if (k == 1) m_act[k] = 0;
        end
      end
      if (done) begin
        if (m_valid[k] && !rdy) m_ovf[k] = 1;
        m_valid[k] = 1;
        m_data[k]  = res & 32'h3F;
      end else if (m_valid[k] && rdy) begin
        m_valid[k] = 0;
      end
    end
  endtask

  initial begin
    tbl[0] = '{16'hFFFF, 1'b0, 16, 6'h10};
    tbl[1] = '{16'h5555, 1'b0, 8,  6'h00};
    tbl[2] = '{16'h0000, 1'b0, 0,  6'h30};
    tbl[3] = '{16'hFFFF, 1'b1, 16, 6'h10};
    tbl[4] = '{16'h0001, 1'b0, 1,  6'h32};
    tbl[5] = '{16'h7FFF, 1'b0, 15, 6'h0E};

    iRstN = 1'b0; iClr = 1'b0; iStart = 1'b0; iEn = 1'b0; iStream = 1'b0; iReady = 1'b0;
    step();
    check("reset_u", {u_data, u_valid, u_busy, u_ovf}, 32'd0);
    check("reset_b", {b_data, b_valid, b_busy, b_ovf}, 32'd0);
    iRstN = 1'b1;
    step();

    // Single windows from the table.
    for (int t = 0; t < 6; t++) begin
      clear_pulse();
      start_pulse();
      check($sformatf("tbl%0d_busy", t), {u_busy, b_busy}, 2'b11);
      feed(tbl[t].bits, tbl[t].gap, 1'b0, -1, $sformatf("tbl%0d", t));
      check($sformatf("tbl%0d_u", t), {u_valid, u_data}, {1'b1, 6'(tbl[t].exp_u)});
      check($sformatf("tbl%0d_b", t), {b_valid, b_data}, {1'b1, 6'(tbl[t].exp_b)});
      check($sformatf("tbl%0d_busy_after", t), {u_busy, b_busy}, 2'b10);
    end

    // Two back-to-back windows with no consumer: the second result overwrites the first.
    clear_pulse();
    start_pulse();
    feed(16'h001F, 1'b0, 1'b0, -1, "ovf_w1");
    check("ovf_w1", {u_valid, u_ovf, u_data}, {2'b10, 6'd5});
    feed(16'h01FF, 1'b0, 1'b0, 5, "ovf_w2");
    check("ovf_w2", {u_valid, u_ovf, u_data}, {2'b11, 6'd9});
    check("ovf_single_shot", {b_valid, b_busy, b_ovf, b_data}, {3'b100, 6'h3A});
    iReady = 1'b1;
    step();
    iReady = 1'b0;
    check("ovf_consume", {u_valid, u_ovf}, 2'b01);

    // The handshake lands on the same edge as the new result, so there is no overflow.
    clear_pulse();
    start_pulse();
    feed(16'h0007, 1'b0, 1'b0, -1, "hs_w1");
    feed(16'h0FFF, 1'b0, 1'b1, 3, "hs_w2");
    check("hs_same_edge", {u_valid, u_ovf, u_data}, {2'b10, 6'd12});
    iReady = 1'b1;
    step();
    iReady = 1'b0;
    check("hs_consume", {u_valid, u_ovf}, 2'b00);

    // Abort after 7 samples with iClr. The following window must count cleanly.
    clear_pulse();
    start_pulse();
    for (int i = 0; i < 7; i++) begin
      iEn = 1'b1; iStream = 1'b1; step();
    end
    iEn = 1'b0;
    clear_pulse();
    check("clr_abort", {u_busy, u_valid, u_ovf, b_busy, b_valid}, 5'b0);
    start_pulse();
    feed(16'h00F0, 1'b0, 1'b0, -1, "clr_next");
    check("clr_next", {u_valid, u_data}, {1'b1, 6'd4});

    // Abort after 7 samples with an asynchronous reset.
    clear_pulse();
    start_pulse();
    for (int i = 0; i < 7; i++) begin
      iEn = 1'b1; iStream = 1'b1; step();
    end
    iEn = 1'b0;
    iRstN = 1'b0;
    #2;
    check("rst_abort", {u_data, u_busy, u_valid, u_ovf}, 32'd0);
    iRstN = 1'b1;
    step();
    start_pulse();
    feed(16'h8001, 1'b0, 1'b0, -1, "rst_next");
    check("rst_next", {u_valid, u_data, b_valid, b_data}, {1'b1, 6'd2, 1'b1, 6'h34});

    // Random traffic, checked against the reference model every cycle.
    iRstN = 1'b0;
    step();
    iRstN = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      iClr    = ($urandom_range(99) < 2);
      iStart  = ($urandom_range(99) < 30);
      iEn     = ($urandom_range(99) < 70);
      iStream = $urandom_range(1);
      iReady  = ($urandom_range(99) < 25);
      for (int k = 0; k < 2; k++) model_step(k, iClr, iStart, iEn, iStream, iReady);
      step();
      check($sformatf("rand_u@%0d", c), {u_valid, u_busy, u_ovf, u_data},
            {m_valid[0], m_act[0], m_ovf[0], 6'(m_data[0])});
      check($sformatf("rand_b@%0d", c), {b_valid, b_busy, b_ovf, b_data},
            {m_valid[1], m_act[1], m_ovf[1], 6'(m_data[1])});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
